timer_slave: RTL and testbench

//   Memory-mapped 32-bit timer on a core slave port (s1 style: we/addr/addr_sel/wdata/rdata).

---
 rtl/timer_slave_pkg.sv | 34 +++
 rtl/timer_prescaler.sv | 29 ++
 rtl/timer_slave.sv | 106 ++++++++++
 tb/tb_timer_slave.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_slave_pkg.sv
// Shared definitions for the memory-mapped timer: register offsets, CTRL bit
// layout and the byte-lane write merge used by every writable register.
package timer_slave_pkg;

    localparam logic [1:0] TMR_CTRL  = 2'd0;
    localparam logic [1:0] TMR_COUNT = 2'd1;
    localparam logic [1:0] TMR_CMP   = 2'd2;
    localparam logic [1:0] TMR_PRESC = 2'd3;

    localparam int TMR_EN   = 0;
    localparam int TMR_IE   = 1;
    localparam int TMR_AUTO = 2;
    localparam int TMR_PEND = 3;

    typedef struct packed {
        logic pend;
        logic auto_rl;
        logic ie;
        logic en;
    } ctrl_t;

    // Replace only the bytes whose lane enable is set.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Clock divider: emits a one-cycle tick every presc+1 enabled clocks.
// The counter holds while disabled and is cleared when the timer is re-enabled.
module timer_prescaler #(
    parameter int PRE_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [PRE_W-1:0] presc,
    output logic             tick
);

    logic [PRE_W-1:0] pre_cnt;

    assign tick = en && (pre_cnt == presc);

    // A shrunken presc below pre_cnt lets the counter run on and wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (clr) begin
            pre_cnt <= '0;
        end else if (en) begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
        end
    end

endmodule

// File: rtl/timer_slave.sv
// 32-bit memory-mapped timer slave: register file, byte-lane writes,
// compare/reload logic, W1C pending flag and registered interrupt.
module timer_slave
    import timer_slave_pkg::*;
#(
    parameter int          CNT_W   = 32,
    parameter int          PRE_W   = 16,
    parameter logic [31:0] CMP_RST = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_we,
    input  logic [31:0] s_addr,
    input  logic [3:0]  s_addr_sel,
    input  logic [31:0] s_wdata,
    output logic [31:0] s_rdata,
    output logic        irq_o
);

    ctrl_t            ctrl;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] cmp;
    logic [PRE_W-1:0] presc;

    logic        tick;
    logic        hit;
    logic        clr;
    logic        wr_ctrl;
    logic        wr_count;
    logic        wr_cmp;
    logic        wr_presc;
    logic [31:0] count_m;
    logic [31:0] cmp_m;
    logic [31:0] presc_m;
    logic        unused;

    assign wr_ctrl  = s_we && (s_addr[3:2] == TMR_CTRL) && s_addr_sel[0];
    assign wr_count = s_we && (s_addr[3:2] == TMR_COUNT) && (|s_addr_sel);
    assign wr_cmp   = s_we && (s_addr[3:2] == TMR_CMP) && (|s_addr_sel);
    assign wr_presc = s_we && (s_addr[3:2] == TMR_PRESC) && (|s_addr_sel);

    assign count_m = lane_merge(32'(count), s_wdata, s_addr_sel);
    assign cmp_m   = lane_merge(32'(cmp), s_wdata, s_addr_sel);
    assign presc_m = lane_merge(32'(presc), s_wdata, s_addr_sel);

    assign hit = tick && (count == cmp);
    assign clr = wr_ctrl && s_wdata[TMR_EN] && !ctrl.en;

    // Bits above the register widths and outside the decoded address are dropped.
    assign unused = ^{s_addr[31:4], s_addr[1:0], count_m, cmp_m, presc_m};

    timer_prescaler #(.PRE_W(PRE_W)) u_presc (
        .clk   (clk),
        .rst   (rst),
        .en    (ctrl.en),
        .clr   (clr),
        .presc (presc),
        .tick  (tick)
    );

    // Later assignments in this block win: software writes override hardware
    // updates, except that a hardware PEND set survives a same-cycle W1C.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl  <= '0;
            count <= '0;
            cmp   <= CNT_W'(CMP_RST);
            presc <= '0;
            irq_o <= 1'b0;
        end else begin
            irq_o <= ctrl.pend & ctrl.ie;

            if (tick) begin
                if (hit) begin
                    if (ctrl.auto_rl) count <= '0;
                    else              ctrl.en <= 1'b0;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end

            if (wr_ctrl) begin
                ctrl.en      <= s_wdata[TMR_EN];
                ctrl.ie      <= s_wdata[TMR_IE];
                ctrl.auto_rl <= s_wdata[TMR_AUTO];
                if (s_wdata[TMR_PEND]) ctrl.pend <= 1'b0;
            end
            if (hit) ctrl.pend <= 1'b1;

            if (wr_count) count <= CNT_W'(count_m);
            if (wr_cmp)   cmp   <= CNT_W'(cmp_m);
            if (wr_presc) presc <= PRE_W'(presc_m);
        end
    end

    always_comb begin
        s_rdata = '0;
        case (s_addr[3:2])
            TMR_CTRL:  s_rdata = {28'd0, ctrl};
            TMR_COUNT: s_rdata = 32'(count);
            TMR_CMP:   s_rdata = 32'(cmp);
            default:   s_rdata = 32'(presc);
        endcase
    end

endmodule

// File: tb/tb_timer_slave.sv
// Bench for timer_slave: register vectors, hand-timed corner sequences and
// a randomized run against a cycle-level behavioural model.
module tb_timer_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_we;
    logic [31:0] s_addr;
    logic [3:0]  s_addr_sel;
    logic [31:0] s_wdata;
    logic [31:0] s_rdata;
    logic        irq_o;

    int checks = 0;
    int errors = 0;

    timer_slave dut (
        .clk        (clk),
        .rst        (rst),
        .s_we       (s_we),
        .s_addr     (s_addr),
        .s_addr_sel (s_addr_sel),
        .s_wdata    (s_wdata),
        .s_rdata    (s_rdata),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    // Reference model state (PRE_W = 16, CNT_W = 32).
    bit          m_en, m_ie, m_auto, m_pend, m_irq;
    logic [31:0] m_count, m_cmp, m_presc, m_pre;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] sel);
        logic [31:0] r = o;
        for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_reg(input int a);
        case (a)
            0:       return {28'd0, m_pend, m_auto, m_ie, m_en};
            1:       return m_count;
            2:       return m_cmp;
            default: return m_presc;
        endcase
    endfunction

    // Next state from the rules: tick when enabled and prescale count reaches PRESC;
    // a tick either matches (PEND, reload or stop) or advances COUNT; software wins.
    task automatic model_edge();
        bit          tick, hit, n_en, n_pend;
        logic [31:0] n_count, n_pre;
        int          a = int'(s_addr[3:2]);
        if (rst) begin
            {m_en, m_ie, m_auto, m_pend, m_irq} = '0;
            m_count = 0; m_cmp = 32'hFFFF_FFFF; m_presc = 0; m_pre = 0;
            return;
        end
        tick    = m_en && (m_pre == m_presc);
        hit     = tick && (m_count == m_cmp);
        m_irq   = m_pend && m_ie;
        n_pre   = !m_en ? m_pre : (tick ? 0 : (m_pre + 1) % 65536);
        n_count = !tick ? m_count : (!hit ? m_count + 1 : (m_auto ? 0 : m_count));
        n_en    = (hit && !m_auto) ? 1'b0 : m_en;
        n_pend  = m_pend || hit;
        if (s_we && s_addr_sel != 0) begin
            if (a == 0 && s_addr_sel[0]) begin
                if (s_wdata[0] && !m_en) n_pre = 0;
                n_en   = s_wdata[0];
                m_ie   = s_wdata[1];
                m_auto = s_wdata[2];
                if (s_wdata[3] && !hit) n_pend = 0;
            end
            if (a == 1) n_count = merge(m_count, s_wdata, s_addr_sel);
            if (a == 2) m_cmp   = merge(m_cmp, s_wdata, s_addr_sel);
            if (a == 3) m_presc = merge(m_presc, s_wdata, s_addr_sel) & 32'hFFFF;
        end
        m_en = n_en; m_pend = n_pend; m_count = n_count; m_pre = n_pre;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic rd_chk(input string nm, input int a, input logic [31:0] exp);
        s_we   = 1'b0;
        s_addr = 32'(a) << 2;
        #1;
        chk(nm, s_rdata, exp);
    endtask

    task automatic wr(input int a, input logic [3:0] sel, input logic [31:0] d);
        s_we = 1'b1; s_addr = 32'(a) << 2; s_addr_sel = sel; s_wdata = d;
        step();
        s_we = 1'b0; s_addr_sel = 4'h0;
    endtask

    typedef struct {
        int          a;
        logic [3:0]  sel;
        logic [31:0] d;
        int          ra;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[9];

    initial begin
        vt[0] = '{2, 4'hF, 32'h1234_5678, 2, 32'h1234_5678};
        vt[1] = '{2, 4'h3, 32'hAABB_CCDD, 2, 32'h1234_CCDD};
        vt[2] = '{1, 4'hF, 32'h0000_0000, 1, 32'h0000_0000};
        vt[3] = '{1, 4'h5, 32'hAABB_CCDD, 1, 32'h00BB_00DD};
        vt[4] = '{1, 4'h0, 32'hFFFF_FFFF, 1, 32'h00BB_00DD};
        vt[5] = '{3, 4'hF, 32'hFFFF_1234, 3, 32'h0000_1234};
        vt[6] = '{0, 4'h1, 32'hFFFF_FFF6, 0, 32'h0000_0006};
        vt[7] = '{0, 4'hE, 32'h0000_00FF, 0, 32'h0000_0006};
        vt[8] = '{0, 4'h1, 32'h0000_0000, 0, 32'h0000_0000};

        rst = 1'b1; s_we = 1'b0; s_addr = '0; s_addr_sel = '0; s_wdata = '0;
        step(); step();
        rst = 1'b0;
        rd_chk("rst ctrl", 0, 32'h0);
        rd_chk("rst count", 1, 32'h0);
        rd_chk("rst cmp", 2, 32'hFFFF_FFFF);
        rd_chk("rst presc", 3, 32'h0);
        chk("rst irq", 32'(irq_o), 32'h0);

        foreach (vt[i]) begin
            wr(vt[i].a, vt[i].sel, vt[i].d);
            rd_chk($sformatf("vec%0d", i), vt[i].ra, vt[i].exp);
            chk($sformatf("vec%0d irq", i), 32'(irq_o), 32'h0);
        end

        // Periodic auto-reload: COUNT 1,2,3,0 repeating, irq one clock after PEND.
        wr(3, 4'hF, 0); wr(2, 4'hF, 3); wr(1, 4'hF, 0); wr(0, 4'hF, 7);
        for (int k = 1; k <= 8; k++) begin
            step();
            rd_chk($sformatf("periodic count k%0d", k), 1, 32'(k % 4));
            if (k == 4) begin
                rd_chk("periodic pend", 0, 32'hF);
                chk("periodic irq lag", 32'(irq_o), 32'h0);
            end
            if (k == 5) chk("periodic irq", 32'(irq_o), 32'h1);
        end
        wr(0, 4'hF, 8);
        rd_chk("periodic w1c", 0, 32'h0);
        step();
        chk("periodic irq drop", 32'(irq_o), 32'h0);

        // One-shot with prescale 3: match on the 2nd tick, EN self-clears, COUNT holds.
        wr(3, 4'hF, 2); wr(2, 4'hF, 1); wr(1, 4'hF, 0); wr(0, 4'hF, 3);
        step(); step(); step();
        rd_chk("oneshot tick1", 1, 32'h1);
        step(); step();
        rd_chk("oneshot pre-match ctrl", 0, 32'h3);
        step();
        rd_chk("oneshot match ctrl", 0, 32'hA);
        rd_chk("oneshot count", 1, 32'h1);
        step();
        chk("oneshot irq", 32'(irq_o), 32'h1);
        step(); step(); step();
        rd_chk("oneshot hold", 1, 32'h1);
        wr(0, 4'hF, 8);
        rd_chk("oneshot clear", 0, 32'h0);
        step();

        // W1C in the match cycle loses to the hardware set.
        wr(3, 4'hF, 0); wr(2, 4'hF, 2); wr(1, 4'hF, 0); wr(0, 4'hF, 7);
        step(); step();
        wr(0, 4'hF, 32'hF);
        rd_chk("w1c race pend kept", 0, 32'hF);
        wr(0, 4'hF, 32'hF);
        rd_chk("w1c clears", 0, 32'h7);
        chk("w1c irq still", 32'(irq_o), 32'h1);
        wr(0, 4'hF, 8);
        chk("w1c irq drop", 32'(irq_o), 32'h0);

        // Software COUNT write beats the increment; all-ones wraps silently.
        wr(3, 4'hF, 0); wr(2, 4'hF, 100); wr(1, 4'hF, 5); wr(0, 4'hF, 1);
        step();
        rd_chk("collide pre", 1, 32'd6);
        wr(1, 4'hF, 10);
        rd_chk("collide write wins", 1, 32'd10);
        step();
        rd_chk("collide resume", 1, 32'd11);
        wr(0, 4'hF, 0);
        wr(1, 4'hF, 32'hFFFF_FFFF); wr(2, 4'hF, 5); wr(0, 4'hF, 1);
        step();
        rd_chk("wrap count", 1, 32'h0);
        rd_chk("wrap no pend", 0, 32'h1);

        // Reset while counting.
        wr(0, 4'hF, 7);
        step(); step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        rd_chk("midrst ctrl", 0, 32'h0);
        rd_chk("midrst count", 1, 32'h0);
        rd_chk("midrst cmp", 2, 32'hFFFF_FFFF);
        chk("midrst irq", 32'(irq_o), 32'h0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int a = 0; a < 4; a++) rd_chk($sformatf("rand c%0d r%0d", c, a), a, model_reg(a));
            chk($sformatf("rand c%0d irq", c), 32'(irq_o), 32'(m_irq));
            rst        = ($urandom_range(0, 499) == 0);
            s_addr     = 32'($urandom_range(0, 3)) << 2 | ($urandom & 32'hFFFF_FFF3);
            s_we       = ($urandom_range(0, 9) == 0);
            s_addr_sel = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
            case (s_addr[3:2])
                2'd1:    s_wdata = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 8));
                2'd2:    s_wdata = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 8));
                2'd3:    s_wdata = 32'($urandom_range(0, 3));
                default: s_wdata = $urandom;
            endcase
            step();
            rst = 1'b0; s_we = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
